// File: rtl/pc_pkg.sv
// Shared definitions for the memory-interface performance counters.
//
// Contents:
//   PC_DATA_WIDTH_DEFAULT - default counter/output width
//   pc_state_t            - tile-tracking state (IDLE=0, BUSY=1)
//   pc_snapshot_t         - snapshot record in downstream packing order:
//                           num_tiles, tot_cycles, tot_requests,
//                           size_per_requests
package pc_pkg;

    localparam int PC_DATA_WIDTH_DEFAULT = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } pc_state_t;

    typedef struct packed {
        logic [PC_DATA_WIDTH_DEFAULT-1:0] num_tiles;
        logic [PC_DATA_WIDTH_DEFAULT-1:0] tot_cycles;
        logic [PC_DATA_WIDTH_DEFAULT-1:0] tot_requests;
        logic [PC_DATA_WIDTH_DEFAULT-1:0] size_per_requests;
    } pc_snapshot_t;

endpackage

// File: rtl/pc_counter.sv
// Enabled incrementer with synchronous clear.
//
// Build option: PC_SATURATE_EN
//   defined   - count sticks at all-ones; ovf pulses when an increment is
//               requested while already at all-ones
//   undefined - count wraps modulo 2^WIDTH; ovf is constant 0
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   clear  in   synchronous clear, overrides inc
//   inc    in   increment request
//   count  out  current count
//   ovf    out  one-cycle pulse on a dropped (saturated) increment
module pc_counter
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_DATA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [WIDTH-1:0] count_next;

`ifdef PC_SATURATE_EN
    logic at_max;
    assign at_max     = &count;
    assign count_next = at_max ? count : count + WIDTH'(1);
    assign ovf        = inc & at_max & ~clear;
`else
    assign count_next = count + WIDTH'(1);
    assign ovf        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_perf_counter.sv
// Per-buffer statistics collector for one memory interface. Counts
// completed tiles, busy cycles, accepted AXI address requests and the size
// of the last accepted request, and presents them through a snapshot stage
// that can be frozen while the writeback unit streams results out.
//
// Build option: PC_SATURATE_EN (saturating counters + sticky pc_overflow);
// without it counters wrap and pc_overflow is 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pc_clear              pulse, zero everything (beats every other input)
//   tile_start/tile_done  tile transfer begin/end pulses
//   req_valid/req_ready   monitored AXI address handshake
//   req_size              size field of the monitored request
//   pc_freeze             hold the snapshot outputs
//   pc_num_tiles, pc_tot_cycles, pc_tot_requests, pc_size_per_requests
//                         snapshot outputs
//   pc_err                sticky protocol error (not frozen)
//   pc_overflow           sticky saturation flag (not frozen)
module mem_perf_counter
    import pc_pkg::*;
#(
    parameter int PC_DATA_WIDTH  = PC_DATA_WIDTH_DEFAULT,
    parameter int REQ_SIZE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_clear,
    input  logic                      tile_start,
    input  logic                      tile_done,
    input  logic                      req_valid,
    input  logic                      req_ready,
    input  logic [REQ_SIZE_WIDTH-1:0] req_size,
    input  logic                      pc_freeze,
    output logic [PC_DATA_WIDTH-1:0]  pc_num_tiles,
    output logic [PC_DATA_WIDTH-1:0]  pc_tot_cycles,
    output logic [PC_DATA_WIDTH-1:0]  pc_tot_requests,
    output logic [PC_DATA_WIDTH-1:0]  pc_size_per_requests,
    output logic                      pc_err,
    output logic                      pc_overflow
);

    pc_state_t state, state_next;
    logic      inc_tiles, inc_cycles, err_set, req_acc;
    logic      err_q;
    logic      ovf_tiles, ovf_cycles, ovf_requests;

    logic [PC_DATA_WIDTH-1:0] num_tiles_p0, tot_cycles_p0, tot_requests_p0, size_p0;
    logic [PC_DATA_WIDTH-1:0] num_tiles_p1, tot_cycles_p1, tot_requests_p1, size_p1;

    assign req_acc = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (reset || pc_clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tile_start) state_next = BUSY;
            BUSY:    if (tile_done && !tile_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A start while busy is flagged but otherwise ignored; done+start in
    // the same BUSY cycle closes one tile and opens the next.
    always_comb begin
        inc_tiles  = 1'b0;
        inc_cycles = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                err_set = tile_done;
            end
            BUSY: begin
                inc_cycles = 1'b1;
                inc_tiles  = tile_done;
                err_set    = tile_start & ~tile_done;
            end
            default: ;
        endcase
    end

    // Stage p0: internal counters
    pc_counter #(.WIDTH(PC_DATA_WIDTH)) u_tiles (
        .clk(clk), .reset(reset), .clear(pc_clear), .inc(inc_tiles),
        .count(num_tiles_p0), .ovf(ovf_tiles)
    );

    pc_counter #(.WIDTH(PC_DATA_WIDTH)) u_cycles (
        .clk(clk), .reset(reset), .clear(pc_clear), .inc(inc_cycles),
        .count(tot_cycles_p0), .ovf(ovf_cycles)
    );

    pc_counter #(.WIDTH(PC_DATA_WIDTH)) u_requests (
        .clk(clk), .reset(reset), .clear(pc_clear), .inc(req_acc),
        .count(tot_requests_p0), .ovf(ovf_requests)
    );

    always_ff @(posedge clk) begin
        if (reset || pc_clear) begin
            size_p0 <= '0;
        end else if (req_acc) begin
            size_p0 <= PC_DATA_WIDTH'(req_size);
        end
    end

    // Stage p1: snapshot, held while frozen; clear still wins
    always_ff @(posedge clk) begin
        if (reset || pc_clear) begin
            num_tiles_p1    <= '0;
            tot_cycles_p1   <= '0;
            tot_requests_p1 <= '0;
            size_p1         <= '0;
        end else if (!pc_freeze) begin
            num_tiles_p1    <= num_tiles_p0;
            tot_cycles_p1   <= tot_cycles_p0;
            tot_requests_p1 <= tot_requests_p0;
            size_p1         <= size_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || pc_clear) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

`ifdef PC_SATURATE_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (reset || pc_clear) begin
            ovf_q <= 1'b0;
        end else if (ovf_tiles || ovf_cycles || ovf_requests) begin
            ovf_q <= 1'b1;
        end
    end
    assign pc_overflow = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused  = ovf_tiles | ovf_cycles | ovf_requests;
    assign pc_overflow = 1'b0;
`endif

    assign pc_num_tiles         = num_tiles_p1;
    assign pc_tot_cycles        = tot_cycles_p1;
    assign pc_tot_requests      = tot_requests_p1;
    assign pc_size_per_requests = size_p1;
    assign pc_err               = err_q;

endmodule

// File: tb/tb_mem_perf_counter.sv
module tb_mem_perf_counter;

    logic        clk = 1'b0;
    logic        reset, pc_clear, tile_start, tile_done;
    logic        req_valid, req_ready, pc_freeze;
    logic [15:0] req_size;

    logic [63:0] o_tiles, o_cycles, o_reqs, o_size;
    logic        o_err, o_ovf;
    logic [3:0]  n_tiles, n_cycles, n_reqs, n_size;
    logic        n_err, n_ovf;
    logic [3:0]  req_size4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign req_size4 = req_size[3:0];

    mem_perf_counter dut (
        .clk(clk), .reset(reset), .pc_clear(pc_clear),
        .tile_start(tile_start), .tile_done(tile_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
        .pc_freeze(pc_freeze),
        .pc_num_tiles(o_tiles), .pc_tot_cycles(o_cycles),
        .pc_tot_requests(o_reqs), .pc_size_per_requests(o_size),
        .pc_err(o_err), .pc_overflow(o_ovf)
    );

    mem_perf_counter #(.PC_DATA_WIDTH(4), .REQ_SIZE_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .pc_clear(pc_clear),
        .tile_start(tile_start), .tile_done(tile_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size4),
        .pc_freeze(pc_freeze),
        .pc_num_tiles(n_tiles), .pc_tot_cycles(n_cycles),
        .pc_tot_requests(n_reqs), .pc_size_per_requests(n_size),
        .pc_err(n_err), .pc_overflow(n_ovf)
    );

    // Reference model for the 64-bit instance: what has happened so far
    // (in_tile, totals) and what the outputs currently show (s_*).
    logic        m_in_tile, m_err;
    logic [63:0] m_tiles, m_cycles, m_reqs, m_size;
    logic [63:0] s_tiles, s_cycles, s_reqs, s_size;

    task automatic model_step();
        if (reset || pc_clear) begin
            m_in_tile = 1'b0; m_err = 1'b0;
            m_tiles = 0; m_cycles = 0; m_reqs = 0; m_size = 0;
            s_tiles = 0; s_cycles = 0; s_reqs = 0; s_size = 0;
        end else begin
            if (!pc_freeze) begin
                s_tiles = m_tiles; s_cycles = m_cycles;
                s_reqs = m_reqs; s_size = m_size;
            end
            if (m_in_tile) begin
                m_cycles = m_cycles + 1;
                if (tile_done) begin
                    m_tiles   = m_tiles + 1;
                    m_in_tile = tile_start;
                end else if (tile_start) begin
                    m_err = 1'b1;
                end
            end else begin
                if (tile_done)  m_err = 1'b1;
                if (tile_start) m_in_tile = 1'b1;
            end
            if (req_valid && req_ready) begin
                m_reqs = m_reqs + 1;
                m_size = {48'd0, req_size};
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pc_clear = 1'b0; tile_start = 1'b0; tile_done = 1'b0;
        req_valid = 1'b0; req_ready = 1'b0; req_size = 16'h0; pc_freeze = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [63:0] t, input logic [63:0] c,
                            input logic [63:0] r, input logic [63:0] s, input logic e);
        chk({tag, ".tiles"}, o_tiles, t);
        chk({tag, ".cycles"}, o_cycles, c);
        chk({tag, ".reqs"}, o_reqs, r);
        chk({tag, ".size"}, o_size, s);
        chk({tag, ".err"}, {63'd0, o_err}, {63'd0, e});
    endtask

    typedef struct {
        logic        start, done, v, r, frz, clr;
        logic [15:0] size;
        logic [63:0] e_tiles, e_cyc, e_req, e_sz;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 64'd0, 64'h0,  1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 64'd0, 64'h0,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 64'd0, 64'd1, 64'd0, 64'h0,  1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd2, 64'd1, 64'h40, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 64'd1, 64'd3, 64'd1, 64'h40, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 64'd1, 64'd3, 64'd1, 64'h40, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0099, 64'd1, 64'd3, 64'd1, 64'h40, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0077, 64'd0, 64'd0, 64'd0, 64'h0,  1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 64'd0, 64'h0,  1'b0};

        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        chk_outs("reset", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        chk("reset.ovf", {63'd0, o_ovf}, 64'd0);
        reset = 1'b0;

        // Table-driven walk through a short tile, requests, error and clear
        for (int i = 0; i < 9; i++) begin
            tile_start = vecs[i].start; tile_done = vecs[i].done;
            req_valid = vecs[i].v; req_ready = vecs[i].r; req_size = vecs[i].size;
            pc_freeze = vecs[i].frz; pc_clear = vecs[i].clr;
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_tiles, vecs[i].e_cyc,
                     vecs[i].e_req, vecs[i].e_sz, vecs[i].e_err);
        end
        idle_inputs();

        // Tile timing: start at 10, done at 17
        for (int c = 0; c <= 20; c++) begin
            tile_start = (c == 10);
            tile_done  = (c == 17);
            tick();
            if (c == 17) chk("timing.tiles_early", o_tiles, 64'd0);
            if (c == 18) chk("timing.tiles_t2", o_tiles, 64'd1);
        end
        chk_outs("timing", 64'd1, 64'd7, 64'd0, 64'd0, 1'b0);

        // Back-to-back tiles
        pc_clear = 1'b1; tick(); pc_clear = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            tile_start = (c == 0) || (c == 5);
            tile_done  = (c == 5) || (c == 9);
            tick();
        end
        idle_inputs();
        chk_outs("b2b", 64'd2, 64'd9, 64'd0, 64'd0, 1'b0);
        tick(); tick(); tick();
        chk("b2b.idle_cycles", o_cycles, 64'd9);

        // Request handshakes: valid 4 cycles, ready in last two
        pc_clear = 1'b1; tick(); pc_clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = 1'b1;
            req_ready = (c >= 2);
            req_size  = (c == 2) ? 16'h0040 : ((c == 3) ? 16'h0080 : 16'h0011);
            tick();
        end
        idle_inputs();
        tick(); tick();
        chk("hs.reqs", o_reqs, 64'd2);
        chk("hs.size", o_size, 64'h80);

        // Freeze for 6 cycles while 3 requests are accepted
        for (int i = 0; i < 6; i++) begin
            pc_freeze = 1'b1;
            req_valid = (i >= 1) && (i <= 3);
            req_ready = req_valid;
            req_size  = 16'h0100 + 16'(i);
            tick();
            chk($sformatf("frz%0d.reqs", i), o_reqs, 64'd2);
            chk($sformatf("frz%0d.size", i), o_size, 64'h80);
        end
        idle_inputs();
        tick();
        chk("unfrz.reqs", o_reqs, 64'd5);
        chk("unfrz.size", o_size, 64'h103);

        // Protocol error, then clear during freeze with a request
        tile_done = 1'b1; tick(); tile_done = 1'b0;
        chk("err.idle_done", {63'd0, o_err}, 64'd1);
        pc_clear = 1'b1; pc_freeze = 1'b1;
        req_valid = 1'b1; req_ready = 1'b1; req_size = 16'h0055;
        tick();
        idle_inputs();
        chk_outs("clr", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        tick(); tick();
        chk_outs("clr.after", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Reset mid-tile aborts it
        tile_start = 1'b1; tick(); tile_start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk_outs("rst_mid", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        tick(); tick();
        chk("rst_mid.cycles", o_cycles, 64'd0);
        tile_done = 1'b1; tick(); tile_done = 1'b0;
        chk("rst_mid.idle", {63'd0, o_err}, 64'd1);

        // 17 tiles into the 4-bit instance
        reset = 1'b1; tick(); reset = 1'b0;
        tile_start = 1'b1; tick();
        for (int i = 0; i < 16; i++) begin
            tile_start = 1'b1; tile_done = 1'b1; tick();
        end
        tile_start = 1'b0; tile_done = 1'b1; tick();
        idle_inputs();
        tick(); tick();
`ifdef PC_SATURATE_EN
        chk("sat.tiles", {60'd0, n_tiles}, 64'd15);
        chk("sat.ovf", {63'd0, n_ovf}, 64'd1);
`else
        chk("wrap.tiles", {60'd0, n_tiles}, 64'd1);
        chk("wrap.ovf", {63'd0, n_ovf}, 64'd0);
`endif
        chk("wide.tiles", o_tiles, 64'd17);

        // Randomized traffic against the model
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            pc_clear   = ($urandom_range(0, 59) == 0);
            tile_start = ($urandom_range(0, 3) == 0);
            tile_done  = ($urandom_range(0, 3) == 0);
            req_valid  = $urandom_range(0, 1) == 1;
            req_ready  = $urandom_range(0, 1) == 1;
            req_size   = 16'($urandom);
            pc_freeze  = ($urandom_range(0, 4) == 0);
            tick();
            chk_outs($sformatf("rnd%0d", i), s_tiles, s_cycles, s_reqs, s_size, m_err);
            chk($sformatf("rnd%0d.ovf", i), {63'd0, o_ovf}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
